// File: rtl/data_ram_sized.sv
// Single-port data memory for the MIPS MEM stage: byte/half/word access,
// MIPS load extension, registered read, fault reporting and a zero-clear sweep.
module data_ram_sized #(
  parameter int ADDR_WIDTH = 14,
  parameter int DEPTH      = 4096,
  parameter int CNT_WIDTH  = 12
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clearReq,
  output logic                  busy,
  input  logic                  req,
  input  logic                  writeEnable,
  input  logic [1:0]            size,
  input  logic                  signedLoad,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [31:0]           writeData,
  output logic [31:0]           readData,
  output logic                  readValid,
  output logic                  exception,
  output logic [1:0]            excCode
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {
    ST_CLEAR,
    ST_READY
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [31:0]          read_data_q, read_data_d;
  logic                 read_valid_q, read_valid_d;
  logic                 exception_q, exception_d;
  logic [1:0]           exc_code_q, exc_code_d;

  logic [31:0]          mem [DEPTH];

  logic                 accept;
  logic [ADDR_WIDTH-3:0] word_addr;
  logic [IDX_W-1:0]     word_idx;
  logic                 fmt_fault;
  logic                 range_fault;
  logic                 fault;
  logic [31:0]          rd_word;
  logic [31:0]          rd_shifted;
  logic [31:0]          load_data;
  logic [3:0]           lane_en;
  logic [31:0]          lane_data;

  logic                 mem_we;
  logic [3:0]           mem_be;
  logic [IDX_W-1:0]     mem_idx;
  logic [31:0]          mem_wdata;

  // Access decode: acceptance, fault classification and word selection
  always_comb begin
    accept      = (state_q == ST_READY) && req;
    word_addr   = address[ADDR_WIDTH-1:2];
    word_idx    = IDX_W'(word_addr);
    fmt_fault   = (size == 2'b11) ||
                  ((size == 2'b01) && address[0]) ||
                  ((size == 2'b10) && (address[1:0] != 2'b00));
    range_fault = 32'(word_addr) >= 32'(DEPTH);
    fault       = fmt_fault || range_fault;
  end

  // Load path: pick the addressed lane(s), move them to bit 0, extend
  always_comb begin
    rd_word    = mem[word_idx];
    rd_shifted = rd_word >> {address[1:0], 3'b000};
    case (size)
      2'b00:   load_data = {{24{signedLoad & rd_shifted[7]}}, rd_shifted[7:0]};
      2'b01:   load_data = {{16{signedLoad & rd_shifted[15]}}, rd_shifted[15:0]};
      default: load_data = rd_shifted;
    endcase
  end

  // Store path: little-endian byte enables with data replicated across lanes
  always_comb begin
    case (size)
      2'b00: begin
        lane_en   = 4'b0001 << address[1:0];
        lane_data = {4{writeData[7:0]}};
      end
      2'b01: begin
        lane_en   = address[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{writeData[15:0]}};
      end
      default: begin
        lane_en   = 4'b1111;
        lane_data = writeData;
      end
    endcase
  end

  // Write port arbitration: the sweep owns the port while clearing
  always_comb begin
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_idx   = '0;
    mem_wdata = '0;
    if (state_q == ST_CLEAR) begin
      mem_we  = 1'b1;
      mem_be  = '1;
      mem_idx = IDX_W'(cnt_q);
    end else if (accept && writeEnable && !fault) begin
      mem_we    = 1'b1;
      mem_be    = lane_en;
      mem_idx   = word_idx;
      mem_wdata = lane_data;
    end
  end

  // Memory array: contents are never reset, the sweep zeroes them instead
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (mem_be[i]) begin
          mem[mem_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
        end
      end
    end
  end

  // Next-state and registered-output computation
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    read_data_d  = read_data_q;
    read_valid_d = 1'b0;
    exception_d  = 1'b0;
    exc_code_d   = 2'b00;
    case (state_q)
      ST_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_WIDTH'(DEPTH - 1)) begin
          state_d = ST_READY;
          cnt_d   = '0;
        end
      end
      default: begin
        if (accept) begin
          if (fault) begin
            exception_d  = 1'b1;
            exc_code_d   = fmt_fault ? (writeEnable ? 2'b10 : 2'b01) : 2'b11;
            read_valid_d = !writeEnable;
            read_data_d  = '0;
          end else if (!writeEnable) begin
            read_valid_d = 1'b1;
            read_data_d  = load_data;
          end
        end
        // The access in this cycle is still serviced; the sweep begins next edge
        if (clearReq) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_CLEAR;
      cnt_q        <= '0;
      read_data_q  <= '0;
      read_valid_q <= 1'b0;
      exception_q  <= 1'b0;
      exc_code_q   <= 2'b00;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      read_data_q  <= read_data_d;
      read_valid_q <= read_valid_d;
      exception_q  <= exception_d;
      exc_code_q   <= exc_code_d;
    end
  end

  assign busy      = (state_q == ST_CLEAR);
  assign readData  = read_data_q;
  assign readValid = read_valid_q;
  assign exception = exception_q;
  assign excCode   = exc_code_q;

endmodule

// File: tb/tb_data_ram_sized.sv
// Self-checking bench for data_ram_sized: directed cases plus randomized
// accesses compared against a byte-array reference model.
module tb_data_ram_sized;

  localparam int AW = 14;
  localparam int D0 = 4096;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;

  logic        clear_req, req, we, sl;
  logic [1:0]  size;
  logic [AW-1:0] addr;
  logic [31:0] wdata;
  logic        busy, rvalid, exc;
  logic [31:0] rdata;
  logic [1:0]  ecode;

  logic        clear_req1, req1, we1, sl1;
  logic [1:0]  size1;
  logic [AW-1:0] addr1;
  logic [31:0] wdata1;
  logic        busy1, rvalid1, exc1;
  logic [31:0] rdata1;
  logic [1:0]  ecode1;

  always #5 clk = ~clk;

  data_ram_sized #(.ADDR_WIDTH(AW), .DEPTH(D0), .CNT_WIDTH(12)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .clearReq(clear_req), .busy(busy),
    .req(req), .writeEnable(we), .size(size), .signedLoad(sl),
    .address(addr), .writeData(wdata), .readData(rdata),
    .readValid(rvalid), .exception(exc), .excCode(ecode)
  );

  data_ram_sized #(.ADDR_WIDTH(AW), .DEPTH(1000), .CNT_WIDTH(10)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .clearReq(clear_req1), .busy(busy1),
    .req(req1), .writeEnable(we1), .size(size1), .signedLoad(sl1),
    .address(addr1), .writeData(wdata1), .readData(rdata1),
    .readValid(rvalid1), .exception(exc1), .excCode(ecode1)
  );

  // Reference model state for u_dut0
  logic [7:0]  m_mem [0:4*D0-1];
  int unsigned m_busy_left;
  logic [31:0] m_rd;
  logic        m_rv, m_ex;
  logic [1:0]  m_ec;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock edge of the reference model, using the inputs presented at that edge
  task automatic model_edge();
    logic [1:0]  code;
    int unsigned nb, base;
    logic [31:0] val;
    m_rv = 1'b0;
    m_ex = 1'b0;
    m_ec = 2'b00;
    if (m_busy_left > 0) begin
      m_busy_left--;
    end else begin
      if (req) begin
        base = int'({18'b0, addr});
        nb   = 1 << size;
        code = 2'b00;
        if (size == 2'd3 || (size == 2'd1 && base % 2 != 0) || (size == 2'd2 && base % 4 != 0))
          code = we ? 2'b10 : 2'b01;
        else if (base / 4 >= D0)
          code = 2'b11;
        if (code != 2'b00) begin
          m_ex = 1'b1;
          m_ec = code;
          m_rv = !we;
          m_rd = '0;
        end else if (we) begin
          for (int unsigned i = 0; i < nb; i++) m_mem[base + i] = wdata[8*i +: 8];
        end else begin
          val = '0;
          for (int unsigned i = 0; i < nb; i++) val = val | (32'(m_mem[base + i]) << (8 * i));
          if (sl && nb < 4 && val[8*nb-1]) val = val | (32'hFFFF_FFFF << (8 * nb));
          m_rd = val;
          m_rv = 1'b1;
        end
      end
      if (clear_req) begin
        for (int i = 0; i < 4 * D0; i++) m_mem[i] = 8'h00;
        m_busy_left = D0;
      end
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    chk({tag, ".busy"}, 32'(busy), 32'(m_busy_left > 0));
    chk({tag, ".rvalid"}, 32'(rvalid), 32'(m_rv));
    chk({tag, ".exc"}, 32'(exc), 32'(m_ex));
    chk({tag, ".ecode"}, 32'(ecode), 32'(m_ec));
    chk({tag, ".rdata"}, rdata, m_rd);
  endtask

  task automatic acc(input string tag, input logic w, input logic [1:0] sz, input logic s,
                     input logic [AW-1:0] a, input logic [31:0] d);
    req = 1'b1; we = w; size = sz; sl = s; addr = a; wdata = d;
    step(tag);
    req = 1'b0;
  endtask

  task automatic acc1(input string tag, input logic w, input logic [1:0] sz,
                      input logic [AW-1:0] a, input logic [31:0] d);
    req1 = 1'b1; we1 = w; size1 = sz; sl1 = 1'b0; addr1 = a; wdata1 = d;
    step(tag);
    req1 = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    clear_req = 0; req = 0; we = 0; sl = 0; size = 0; addr = '0; wdata = '0;
    clear_req1 = 0; req1 = 0; we1 = 0; sl1 = 0; size1 = 0; addr1 = '0; wdata1 = '0;
    for (int i = 0; i < 4 * D0; i++) m_mem[i] = 8'h00;
    m_busy_left = D0; m_rd = '0; m_rv = 0; m_ex = 0; m_ec = 0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst.busy", 32'(busy), 32'd1);
    chk("rst.rdata", rdata, 32'h0);
    chk("rst.rvalid", 32'(rvalid), 32'd0);
    chk("rst.exc", 32'(exc), 32'd0);
    chk("rst.ecode", 32'(ecode), 32'd0);
    reset_n = 1'b1;

    // Initial sweep: random traffic and a clear request must be ignored
    cnt = 0;
    while (busy && cnt < 5000) begin
      cnt++;
      req = 1'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));
      size = 2'd2;
      addr = AW'($urandom_range(0, D0 - 1) * 4);
      wdata = $urandom;
      clear_req = (cnt == 100);
      step("sweep0");
    end
    req = 0; clear_req = 0;
    chk("sweep0.len", 32'(cnt), 32'd4096);

    acc("lw0", 0, 2'd2, 0, 14'h0000, 0);
    chk("lw0.const", rdata, 32'h0);

    acc("sw10", 1, 2'd2, 0, 14'h0010, 32'h80FF7F01);
    acc("lb11s", 0, 2'd0, 1, 14'h0011, 0);
    chk("lb11s.const", rdata, 32'h0000007F);
    acc("lb13s", 0, 2'd0, 1, 14'h0013, 0);
    chk("lb13s.const", rdata, 32'hFFFFFF80);
    acc("lbu13", 0, 2'd0, 0, 14'h0013, 0);
    chk("lbu13.const", rdata, 32'h00000080);
    acc("lh12s", 0, 2'd1, 1, 14'h0012, 0);
    chk("lh12s.const", rdata, 32'hFFFF80FF);

    acc("sw10b", 1, 2'd2, 0, 14'h0010, 32'h11223344);
    acc("sb12", 1, 2'd0, 0, 14'h0012, 32'h000000AA);
    acc("lw10a", 0, 2'd2, 0, 14'h0010, 0);
    chk("lw10a.const", rdata, 32'h11AA3344);
    acc("sh10", 1, 2'd1, 0, 14'h0010, 32'h0000BEEF);
    acc("lw10b", 0, 2'd2, 0, 14'h0010, 0);
    chk("lw10b.const", rdata, 32'h11AABEEF);
    step("idle_hold");
    chk("idle_hold.const", rdata, 32'h11AABEEF);

    acc("lw6", 0, 2'd2, 0, 14'h0006, 0);
    chk("lw6.ecode", 32'(ecode), 32'd1);
    chk("lw6.rdata", rdata, 32'h0);
    acc("sw4", 1, 2'd2, 0, 14'h0004, 32'hCAFEF00D);
    acc("sh5", 1, 2'd1, 0, 14'h0005, 32'h00001234);
    chk("sh5.ecode", 32'(ecode), 32'd2);
    chk("sh5.rvalid", 32'(rvalid), 32'd0);
    acc("lw4", 0, 2'd2, 0, 14'h0004, 0);
    chk("lw4.const", rdata, 32'hCAFEF00D);
    acc("ld_sz3", 0, 2'd3, 0, 14'h0008, 0);
    chk("ld_sz3.ecode", 32'(ecode), 32'd1);

    // Range checks on the 1000-word instance
    acc1("d1.sw", 1, 2'd2, 14'h0F9C, 32'h12345678);
    chk("d1.sw.exc", 32'(exc1), 32'd0);
    acc1("d1.lw_last", 0, 2'd2, 14'h0F9C, 0);
    chk("d1.lw_last.rvalid", 32'(rvalid1), 32'd1);
    chk("d1.lw_last.rdata", rdata1, 32'h12345678);
    acc1("d1.lw_oor", 0, 2'd2, 14'h0FA0, 0);
    chk("d1.lw_oor.exc", 32'(exc1), 32'd1);
    chk("d1.lw_oor.ecode", 32'(ecode1), 32'd3);
    chk("d1.lw_oor.rdata", rdata1, 32'h0);
    acc1("d1.sb_mis", 1, 2'd1, 14'h0FA1, 0);
    chk("d1.sb_mis.ecode", 32'(ecode1), 32'd2);

    // Randomized traffic in a small window so stores and loads collide
    for (int n = 0; n < 400; n++) begin
      acc("rand", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
          AW'($urandom_range(0, 63)), $urandom);
      if ($urandom_range(0, 3) == 0) step("rand_idle");
    end

    // Clear request together with a load: the load sees the old data
    acc("sw_pre", 1, 2'd2, 0, 14'h0010, 32'h5A5A1234);
    clear_req = 1;
    acc("clr_load", 0, 2'd2, 0, 14'h0010, 0);
    clear_req = 0;
    chk("clr_load.const", rdata, 32'h5A5A1234);
    chk("clr_load.busy", 32'(busy), 32'd1);

    cnt = 0;
    while (busy && cnt < 5000) begin
      cnt++;
      req = 1'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));
      size = 2'd2;
      addr = AW'($urandom_range(0, 63) * 4);
      wdata = $urandom | 32'h1;
      clear_req = (cnt == 2000);
      step("sweep1");
    end
    req = 0; clear_req = 0;
    chk("sweep1.len", 32'(cnt), 32'd4096);

    for (int i = 0; i < D0; i++) begin
      acc("zero", 0, 2'd2, 0, AW'(i * 4), 0);
    end
    chk("zero.last", rdata, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
